// File: rtl/tdc_pkg.sv
// Shared types and defaults for the tdc_pulse_gen digital-to-time converter.
package tdc_pkg;

  localparam int unsigned DEFAULT_BIT_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    GAP   = 2'd3
  } tdc_pg_state_t;

endpackage

// File: rtl/tdc_req_buffer.sv
// One-entry holding register for a {delay, width} request waiting behind an active pulse.
module tdc_req_buffer
  import tdc_pkg::*;
#(
  parameter int unsigned BIT_COUNT = DEFAULT_BIT_COUNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clear,
  input  logic [BIT_COUNT-1:0] in_delay,
  input  logic [BIT_COUNT-1:0] in_width,
  output logic                 full,
  output logic [BIT_COUNT-1:0] delay,
  output logic [BIT_COUNT-1:0] width
);

  // Valid flag and payload; clear wins over a same-edge push so a dropped request stays dropped.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full  <= 1'b0;
      delay <= '0;
      width <= '0;
    end else if (push) begin
      full  <= 1'b1;
      delay <= in_delay;
      width <= in_width;
    end else if (pop) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/tdc_pulse_gen.sv
// Pulse generator: accepted {delay, width} produces one pulse high in cycles
// T+1+delay .. T+delay+width after accept edge T, then a MIN_GAP low gap.
// Optional abort input is enabled by defining TDC_PULSE_GEN_ABORT_EN.
module tdc_pulse_gen
  import tdc_pkg::*;
#(
  parameter int unsigned BIT_COUNT = DEFAULT_BIT_COUNT,
  parameter int unsigned MIN_GAP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef TDC_PULSE_GEN_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BIT_COUNT-1:0] req_delay,
  input  logic [BIT_COUNT-1:0] req_width,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [BIT_COUNT-1:0] GAP_LOAD = BIT_COUNT'(MIN_GAP);
  localparam logic [BIT_COUNT-1:0] ONE      = BIT_COUNT'(1);

  tdc_pg_state_t        state_q, state_d;
  logic [BIT_COUNT-1:0] cnt_q, cnt_d;
  logic [BIT_COUNT-1:0] width_q, width_d;
  logic                 done_d;

  logic                 buf_full;
  logic [BIT_COUNT-1:0] buf_delay, buf_width;
  logic                 push, pop, clear;

  logic                 accept;
  logic                 abort_hit;
  logic                 launch, go_pulse;
  logic [BIT_COUNT-1:0] l_delay, l_width, p_width;

  assign req_ready = !reset && !buf_full;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE) || buf_full;
  assign push      = accept && (state_q != IDLE);

`ifdef TDC_PULSE_GEN_ABORT_EN
  assign abort_hit = abort && ((state_q != IDLE) || buf_full);
`else
  assign abort_hit = 1'b0;
`endif

  tdc_req_buffer #(
    .BIT_COUNT (BIT_COUNT)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .in_delay (req_delay),
    .in_width (req_width),
    .full     (buf_full),
    .delay    (buf_delay),
    .width    (buf_width)
  );

  // Next-state, counter and strobe logic; launches come from the bypass path or the buffer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    launch   = 1'b0;
    go_pulse = 1'b0;
    l_delay  = req_delay;
    l_width  = req_width;
    p_width  = width_q;

    case (state_q)
      IDLE: begin
        if (buf_full) begin
          launch  = 1'b1;
          pop     = 1'b1;
          l_delay = buf_delay;
          l_width = buf_width;
        end else if (accept) begin
          launch = 1'b1;
        end
      end
      DELAY: begin
        if (cnt_q == ONE) go_pulse = 1'b1;
        else              cnt_d    = cnt_q - ONE;
      end
      HIGH: begin
        if (cnt_q == ONE) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (cnt_q == ONE) begin
          if (buf_full) begin
            launch  = 1'b1;
            pop     = 1'b1;
            l_delay = buf_delay;
            l_width = buf_width;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Start a request: zero delay goes straight to the pulse phase.
    if (launch) begin
      width_d = l_width;
      if (l_delay == '0) begin
        go_pulse = 1'b1;
        p_width  = l_width;
      end else begin
        state_d = DELAY;
        cnt_d   = l_delay;
      end
    end

    // Enter the pulse phase; zero width skips HIGH but still completes.
    if (go_pulse) begin
      if (p_width == '0) begin
        state_d = GAP;
        cnt_d   = GAP_LOAD;
        done_d  = 1'b1;
      end else begin
        state_d = HIGH;
        cnt_d   = p_width;
      end
    end

    // Abort drops everything in flight and (re)starts the gap.
    if (abort_hit) begin
      state_d = GAP;
      cnt_d   = GAP_LOAD;
      done_d  = 1'b0;
      pop     = 1'b0;
      clear   = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      pulse_out <= (state_d == HIGH);
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Directed bench for tdc_pulse_gen (BIT_COUNT=8, MIN_GAP=1).
module tb_tdc_pulse_gen;

  localparam int unsigned BC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [BC-1:0] req_delay;
  logic [BC-1:0] req_width;
  logic          pulse_out;
  logic          busy;
  logic          done;
`ifdef TDC_PULSE_GEN_ABORT_EN
  logic          abort;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  tdc_pulse_gen #(
    .BIT_COUNT (BC),
    .MIN_GAP   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TDC_PULSE_GEN_ABORT_EN
    .abort     (abort),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_delay (req_delay),
    .req_width (req_width),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, got, exp);
    end
  endtask

  // Present one request for exactly one edge (the accept edge T).
  task automatic send(input int d, input int w);
    req_valid = 1'b1;
    req_delay = BC'(d);
    req_width = BC'(w);
    #1;
    chk("ready_at_send", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  // Check cycles T+1 .. T+n of a lone request against the documented latency.
  task automatic run_pulse(input int d, input int w, input int n);
    for (int k = 1; k <= n; k++) begin
      chk("pulse", pulse_out, (k >= 1 + d) && (k <= d + w));
      chk("done",  done,      k == 1 + d + w);
      chk("busy",  busy,      k <= d + w + 1);
      chk("ready", req_ready, 1'b1);
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_delay = '0;
    req_width = '0;
`ifdef TDC_PULSE_GEN_ABORT_EN
    abort     = 1'b0;
`endif

    // Reset state.
    tick();
    tick();
    chk("rst_pulse", pulse_out, 1'b0);
    chk("rst_done",  done,      1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_ready", req_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);

    // delay=3 width=5: high T+4..T+8, done T+9.
    send(3, 5);
    run_pulse(3, 5, 12);

    // delay=0 width=1: single high cycle at T+1.
    send(0, 1);
    run_pulse(0, 1, 4);

    // delay=2 width=0: no high cycle, done at T+3.
    send(2, 0);
    run_pulse(2, 0, 5);

    // Back-to-back {1,4} then {0,2}: second goes through the buffer.
    req_valid = 1'b1;
    req_delay = BC'(1);
    req_width = BC'(4);
    #1;
    chk("b2b_ready0", req_ready, 1'b1);
    tick();
    chk("b2b_pulse1", pulse_out, 1'b0);
    chk("b2b_ready1", req_ready, 1'b1);
    req_delay = BC'(0);
    req_width = BC'(2);
    tick();
    req_valid = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      chk("b2b_pulse", pulse_out, ((k >= 2) && (k <= 5)) || ((k >= 7) && (k <= 8)));
      chk("b2b_done",  done,      (k == 6) || (k == 9));
      chk("b2b_ready", req_ready, k >= 7);
      chk("b2b_busy",  busy,      k <= 9);
      tick();
    end

    // Reset in the middle of HIGH with the buffer full.
    send(2, 6);
    req_valid = 1'b1;
    req_delay = BC'(1);
    req_width = BC'(1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("mr_ready_full", req_ready, 1'b0);
    chk("mr_busy",       busy,      1'b1);
    tick();
    chk("mr_high1", pulse_out, 1'b1);
    tick();
    chk("mr_high2", pulse_out, 1'b1);
    reset = 1'b1;
    tick();
    chk("mr_pulse",     pulse_out, 1'b0);
    chk("mr_busy0",     busy,      1'b0);
    chk("mr_done",      done,      1'b0);
    chk("mr_ready_rst", req_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("mr_ready_after", req_ready, 1'b1);
    for (int k = 0; k < 12; k++) begin
      chk("mr_quiet_pulse", pulse_out, 1'b0);
      chk("mr_quiet_done",  done,      1'b0);
      chk("mr_quiet_busy",  busy,      1'b0);
      tick();
    end

    // Maximum fields for 8-bit counters: 255 high cycles, no wrap.
    send(255, 255);
    run_pulse(255, 255, 515);

`ifdef TDC_PULSE_GEN_ABORT_EN
    // Abort in the 2nd HIGH cycle with a buffered request pending.
    send(0, 10);
    chk("ab_high1", pulse_out, 1'b1);
    req_valid = 1'b1;
    req_delay = BC'(1);
    req_width = BC'(1);
    tick();
    req_valid = 1'b0;
    chk("ab_high2",  pulse_out, 1'b1);
    chk("ab_full",   req_ready, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_pulse_low", pulse_out, 1'b0);
    chk("ab_no_done",   done,      1'b0);
    chk("ab_buf_clear", req_ready, 1'b1);
    chk("ab_gap_busy",  busy,      1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("ab_quiet_pulse", pulse_out, 1'b0);
      chk("ab_quiet_done",  done,      1'b0);
      chk("ab_quiet_busy",  busy,      1'b0);
      tick();
    end
    send(2, 3);
    run_pulse(2, 3, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_pulse_gen.md
Name: tdc_pulse_gen

Overview:
- Digital-to-time converter: the transmit-side counterpart of the TDC time-difference measurement.
- Accepts a request of {delay, width} in clock cycles and emits one pulse on pulse_out: rises delay+1 cycles after acceptance and stays high exactly width cycles.
- Drives the TDC under test (or its model) with known intervals; a one-entry request buffer allows back-to-back pulses.

Parameters:
- BIT_COUNT, 32, width of the delay/width fields and internal counters.
- MIN_GAP, 1, minimum low cycles on pulse_out between consecutive pulses; legal range is 1 or more, so a falling edge is always visible to the TDC.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted; transfer occurs when req_valid && req_ready at a clk edge.
- req_delay  input  BIT_COUNT  cycles from acceptance+1 to the rising edge of pulse_out.
- req_width  input  BIT_COUNT  high time of pulse_out in cycles.
- pulse_out  output  1  generated pulse; registered, glitch-free.
- busy  output  1  FSM not IDLE, or buffer occupied.
- done  output  1  one-cycle strobe per completed request.

Behaviour:
- Reset values: pulse_out=0, done=0, busy=0, buffer empty, FSM=IDLE. req_ready=0 while reset is high and 1 on the first cycle after reset.
- req_ready = !reset && !buf_valid (combinational). The FSM itself never backpressures; only the one-entry buffer does.
- FSM states: IDLE, DELAY, HIGH, GAP.
  - IDLE: on accept, load delay_cnt=req_delay. Go to DELAY, or directly to HIGH if req_delay=0 (pulse_out=1 the cycle after accept). The request bypasses the buffer.
  - DELAY: decrement delay_cnt. When it reaches 0, go to HIGH next edge with width_cnt=width.
  - HIGH: pulse_out=1, width_cnt decrements. After width cycles go to GAP with pulse_out=0. done=1 for exactly the first GAP cycle.
  - GAP: pulse_out=0 for MIN_GAP cycles. At the end, if buf_valid, launch the buffered request as if accepted that edge and clear the buffer; otherwise go to IDLE.
- Latency: accept at edge T. pulse_out is high in cycles T+1+delay .. T+delay+width. done fires in cycle T+1+delay+width.
- width=0: no high cycle. The FSM goes DELAY -> GAP, pulse_out stays 0, and done still fires at T+1+delay.
- Buffer: accept while not IDLE stores {delay,width}. The buffer is held until GAP ends.
- Simultaneous events: accept on the same edge GAP ends with an empty buffer goes to the buffer, then launches next cycle (1-cycle extra gap). Accept in IDLE never touches the buffer.
- Counters are BIT_COUNT wide, with no wrap. Max delay and width are 2^BIT_COUNT-1.
- Reset mid-operation: next edge forces pulse_out=0, FSM=IDLE, buffer cleared, done=0. The in-flight request is lost and no done is issued.
- busy = (state!=IDLE) || buf_valid.

Optional Feature:
- Macro TDC_PULSE_GEN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge: FSM goes to GAP and the buffer is cleared. pulse_out=0 from the next cycle.
  - No done for aborted or dropped requests. req_ready is unaffected by abort itself.
  - abort in IDLE with an empty buffer has no effect. abort in GAP restarts the gap count.
- Undefined: the abort port does not exist, and every accepted request completes unless reset.

Decomposition:
- Package tdc_pkg holds:
  - typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} tdc_pg_state_t.
  - localparam DEFAULT_BIT_COUNT=32.
- Sub-module tdc_req_buffer holds the one-entry valid/data register, taking BIT_COUNT as a parameter. Its ports: push, pop, clear, full, delay/width out.
- The FSM and counters stay in tdc_pulse_gen.

Test Plan:
- Reset then request delay=3, width=5 accepted at edge T -> pulse_out high in cycles T+4..T+8; done in T+9; req_ready=1 throughout.
- delay=0, width=1 -> pulse_out high exactly one cycle, at T+1. width=0, delay=2 -> pulse_out stays 0, done at T+3.
- Back-to-back: hold req_valid with {1,4} then {0,2}, MIN_GAP=1 -> second accepted while busy, req_ready=0 until the first GAP ends; exactly 1 low cycle between pulses; two done strobes.
- Assert reset for one cycle in the middle of HIGH with the buffer full -> pulse_out=0 next cycle; busy=0; no done; req_ready=1 after reset.
- BIT_COUNT=8, width=255, delay=255 -> 255 high cycles, no counter wrap.
- TDC_PULSE_GEN_ABORT_EN: abort in the 2nd cycle of HIGH (width=10) -> pulse_out low next cycle, buffer cleared, no done; a new request after the GAP produces a correct pulse.
